fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core. It owns the program counter, issues requests to a variable-latency instruction memory, and selects the next PC from sequential, branch or jump sources. It presents the fetched instruction, PC+4 and PC page to the IF/ID pipeline register, plus a valid flag the hazard unit uses to stall or bubble that register.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency instruction memory, selects next PC.
// Optional FETCH_STALL_CNT_EN adds a free-running count of cycles without a valid fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [3:0]  jump_page,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_plus_4_out,
    output logic [3:0]  pc_page_out,
`ifdef FETCH_STALL_CNT_EN
    output logic        fetch_valid,
    output logic [31:0] fetch_stall_cnt
`else
    output logic        fetch_valid
`endif
);

    typedef enum logic [1:0] {REQ, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ibuf;
    logic [31:0] redir_target;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_next_seq;

    assign redirect    = jump | branch_taken;
    assign target      = jump ? {jump_page, jump_index, 2'b00} : branch_target;
    assign pc_next_seq = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= REQ;
            pc           <= RESET_PC;
            ibuf         <= 32'h0;
            redir_target <= 32'h0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            pc <= target;
                        end else if (pc_write) begin
                            pc <= pc_next_seq;
                        end else begin
                            ibuf  <= imem_rdata;
                            state <= HOLD;
                        end
                    end else if (redirect) begin
                        redir_target <= target;
                        state        <= DROP;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (pc_write) begin
                        pc    <= pc_next_seq;
                        state <= REQ;
                    end
                end
                DROP: begin
                    // the old request must complete before the redirected one is issued
                    if (imem_ready) begin
                        pc    <= redirect ? target : redir_target;
                        state <= REQ;
                    end else if (redirect) begin
                        redir_target <= target;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    assign imem_req        = !rst && (state != HOLD);
    assign imem_addr       = pc;
    assign fetch_valid     = !rst && (((state == REQ) && imem_ready) || (state == HOLD));
    assign instruction_out = !fetch_valid ? 32'h0 :
                             (state == HOLD) ? ibuf : imem_rdata;
    assign pc_plus_4_out   = pc_next_seq;
    assign pc_page_out     = pc_next_seq[31:28];

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_stall_cnt <= 32'h0;
        end else if (!fetch_valid) begin
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with a per-cycle expected-output scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic [3:0]  jump_page = 4'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction_out;
    logic [31:0] pc_plus_4_out;
    logic [3:0]  pc_page_out;
    logic        fetch_valid;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] fetch_stall_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index), .jump_page(jump_page),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction_out(instruction_out), .pc_plus_4_out(pc_plus_4_out),
        .pc_page_out(pc_page_out),
`ifdef FETCH_STALL_CNT_EN
        .fetch_valid(fetch_valid),
        .fetch_stall_cnt(fetch_stall_cnt)
`else
        .fetch_valid(fetch_valid)
`endif
    );

    typedef struct {
        logic        pw;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [25:0] ji;
        logic [3:0]  jp;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic add(input logic pw, input logic br, input logic [31:0] bt,
                       input logic j, input logic [25:0] ji, input logic [3:0] jp,
                       input logic rdy, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4);
        vec_t v;
        v.pw = pw; v.br = br; v.bt = bt; v.j = j; v.ji = ji; v.jp = jp;
        v.rdy = rdy; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc4 = e_pc4;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic e_req, input logic [31:0] e_addr,
                         input logic chk_addr, input logic e_valid,
                         input logic [31:0] e_instr, input logic [31:0] e_pc4);
        vec_cnt++;
        if (imem_req !== e_req || (chk_addr && imem_addr !== e_addr) ||
            fetch_valid !== e_valid || instruction_out !== e_instr ||
            pc_plus_4_out !== e_pc4 || pc_page_out !== e_pc4[31:28]) begin
            err_cnt++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc4=%h page=%h, want req=%0b addr=%h valid=%0b instr=%h pc4=%h page=%h",
                     nm, imem_req, imem_addr, fetch_valid, instruction_out, pc_plus_4_out,
                     pc_page_out, e_req, e_addr, e_valid, e_instr, e_pc4, e_pc4[31:28]);
        end
    endtask

`ifdef FETCH_STALL_CNT_EN
    task automatic check_cnt(input string nm, input logic [31:0] e);
        vec_cnt++;
        if (fetch_stall_cnt !== e) begin
            err_cnt++;
            $display("FAIL %s: got stall_cnt=%0d want %0d", nm, fetch_stall_cnt, e);
        end
    endtask
`endif

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    initial begin
        vec_t e;
        // zero-wait fetch from reset PC
        add(1,0,0,0,0,0, 1,ins(32'h40), 1,32'h40,1,ins(32'h40),32'h44);
        add(1,0,0,0,0,0, 1,ins(32'h44), 1,32'h44,1,ins(32'h44),32'h48);
        add(1,0,0,0,0,0, 1,ins(32'h48), 1,32'h48,1,ins(32'h48),32'h4C);
        // 3-cycle latency
        for (int k = 0; k < 3; k++) add(1,0,0,0,0,0, 0,JUNK, 1,32'h4C,0,0,32'h50);
        add(1,0,0,0,0,0, 1,ins(32'h4C), 1,32'h4C,1,ins(32'h4C),32'h50);
        // pc_write stall at ready: instruction held from ibuf
        add(0,0,0,0,0,0, 1,32'h8C22_0004, 1,32'h50,1,32'h8C22_0004,32'h54);
        for (int k = 0; k < 3; k++) add(0,0,0,0,0,0, 0,JUNK, 0,32'h50,1,32'h8C22_0004,32'h54);
        add(1,0,0,0,0,0, 0,JUNK, 0,32'h50,1,32'h8C22_0004,32'h54);
        // branch at ready, then branch during a 2-cycle wait
        add(1,1,32'h20,0,0,0, 1,ins(32'h54), 1,32'h54,1,ins(32'h54),32'h58);
        add(1,0,0,0,0,0, 0,JUNK, 1,32'h20,0,0,32'h24);
        add(1,1,32'h100,0,0,0, 0,JUNK, 1,32'h20,0,0,32'h24);
        add(1,0,0,0,0,0, 1,ins(32'h20), 1,32'h20,0,0,32'h24);
        // jump beats branch in the same cycle
        add(1,1,32'h200,1,26'h10,4'h1, 1,ins(32'h100), 1,32'h100,1,ins(32'h100),32'h104);
        add(1,0,0,0,0,0, 0,JUNK, 1,32'h1000_0040,0,0,32'h1000_0044);
        // two redirects while dropping: latest wins
        add(1,1,32'h300,0,0,0, 0,JUNK, 1,32'h1000_0040,0,0,32'h1000_0044);
        add(1,0,0,1,26'h100,4'h0, 0,JUNK, 1,32'h1000_0040,0,0,32'h1000_0044);
        add(1,0,0,0,0,0, 1,ins(32'h1000_0040), 1,32'h1000_0040,0,0,32'h1000_0044);
        add(1,0,0,0,0,0, 1,ins(32'h400), 1,32'h400,1,ins(32'h400),32'h404);
        // jump to the top of the address space, then wrap
        add(1,0,0,1,26'h3FF_FFFF,4'hF, 1,ins(32'h404), 1,32'h404,1,ins(32'h404),32'h408);
        add(1,0,0,0,0,0, 1,ins(32'hFFFF_FFFC), 1,32'hFFFF_FFFC,1,ins(32'hFFFF_FFFC),32'h0);
        add(1,0,0,0,0,0, 0,JUNK, 1,32'h0,0,0,32'h4);

        repeat (2) @(negedge clk);
        #1 check("reset_state", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h44);
`ifdef FETCH_STALL_CNT_EN
        check_cnt("reset_cnt", 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            pc_write = vecs[i].pw; branch_taken = vecs[i].br; branch_target = vecs[i].bt;
            jump = vecs[i].j; jump_index = vecs[i].ji; jump_page = vecs[i].jp;
            imem_ready = vecs[i].rdy; imem_rdata = vecs[i].rd;
            sb.push_back(vecs[i]);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d", i), e.e_req, e.e_addr, 1'b1, e.e_valid, e.e_instr, e.e_pc4);
        end

        // reset pulsed mid-wait: request withdrawn at once
        @(negedge clk);
        pc_write = 1'b1; branch_taken = 1'b0; jump = 1'b0;
        imem_ready = 1'b0; imem_rdata = JUNK;
        #1 check("midwait", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4);
        #1 rst = 1'b1;
        #1 check("rst_async", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h44);
`ifdef FETCH_STALL_CNT_EN
        check_cnt("rst_cnt", 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_req", 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h44);
        @(negedge clk);
        #1 check("post_rst_wait", 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h44);
`ifdef FETCH_STALL_CNT_EN
        check_cnt("stall_cnt1", 32'h1);
`endif
        @(negedge clk);
        imem_ready = 1'b1; imem_rdata = ins(32'h40);
        #1 check("post_rst_data", 1'b1, 32'h40, 1'b1, 1'b1, ins(32'h40), 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
